// File: rtl/case_pkg.sv
// Shared types, command bytes and the case transform
// used by the stream scheduler.
package case_pkg;

  typedef enum logic [1:0] {
    MODE_N = 2'd0,
    MODE_L = 2'd1,
    MODE_U = 2'd2,
    MODE_C = 2'd3
  } case_mode_t;

  localparam logic [7:0] CH_ESC = 8'h1B;
  localparam logic [7:0] CH_L   = 8'h4C;
  localparam logic [7:0] CH_U   = 8'h55;
  localparam logic [7:0] CH_N   = 8'h4E;
  localparam logic [7:0] CH_C   = 8'h43;

  function automatic logic [7:0] xform(
    input logic [7:0] b,
    input case_mode_t m
  );
    logic       up;
    logic       lo;
    logic [7:0] r;
    up = (b >= 8'h41) && (b <= 8'h5A);
    lo = (b >= 8'h61) && (b <= 8'h7A);
    r  = b;
    case (m)
      MODE_L: if (up) r = b + 8'h20;
      MODE_U: if (lo) r = b - 8'h20;
      MODE_C: begin
        if (up)      r = b + 8'h20;
        else if (lo) r = b - 8'h20;
      end
      default: r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/case_stream_sched_rr_arbiter.sv
// Round-robin picker: first active request at or
// after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  function automatic logic [IDW-1:0] wrap(
    input logic [IDW-1:0] p,
    input int             k
  );
    int s;
    s = (int'(p) + k) % NREQ;
    return IDW'(s);
  endfunction

  // Scan from ptr and take the first requester found
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (en && !any && req[wrap(ptr, k)]) begin
        gnt[wrap(ptr, k)] = 1'b1;
        gnt_id            = wrap(ptr, k);
        any               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/case_stream_sched.sv
// Shares one case-transform datapath among NREQ byte
// streams, each with its own in-band escape-set mode.
module case_stream_sched
  import case_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready,
  output logic [2*NREQ-1:0] mode,
  output logic              cmd_err,
  output logic [IDW-1:0]    err_id
);

  case_mode_t      r_mode [NREQ];
  logic [NREQ-1:0] r_esc;
  logic [IDW-1:0]  r_ptr;
  logic            r_ov;
  logic [7:0]      r_od;
  logic [IDW-1:0]  r_oid;
  logic            r_err;
  logic [IDW-1:0]  r_eid;

  logic            w_free;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gid;
  logic            w_any;
  logic [7:0]      w_b;
  logic            w_emit;
  logic [7:0]      w_edata;
  logic            w_set_esc;
  logic            w_clr_esc;
  logic            w_set_mode;
  case_mode_t      w_new_mode;
  logic            w_bad;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [2*NREQ-1:0] w_mode;

  assign w_free = !r_ov || out_ready;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (r_ptr),
    .en     (w_free),
    .gnt    (w_gnt),
    .gnt_id (w_gid),
    .any    (w_any)
  );

  assign req_ready = w_gnt;
  assign w_b       = req_data[8*w_gid +: 8];
  assign w_ptr_nxt = (w_gid == IDW'(NREQ - 1))
                   ? '0 : w_gid + 1'b1;

  // Classify the granted byte against its owner's state
  always_comb begin
    w_emit     = 1'b0;
    w_edata    = 8'h00;
    w_set_esc  = 1'b0;
    w_clr_esc  = 1'b0;
    w_set_mode = 1'b0;
    w_new_mode = MODE_N;
    w_bad      = 1'b0;
    if (w_any) begin
      if (!r_esc[w_gid]) begin
        if (w_b == CH_ESC) begin
          w_set_esc = 1'b1;
        end else begin
          w_emit  = 1'b1;
          w_edata = xform(w_b, r_mode[w_gid]);
        end
      end else begin
        w_clr_esc = 1'b1;
        unique case (1'b1)
          (w_b == CH_L): begin
            w_set_mode = 1'b1;
            w_new_mode = MODE_L;
          end
          (w_b == CH_U): begin
            w_set_mode = 1'b1;
            w_new_mode = MODE_U;
          end
          (w_b == CH_N): begin
            w_set_mode = 1'b1;
            w_new_mode = MODE_N;
          end
          (w_b == CH_C): begin
            w_set_mode = 1'b1;
            w_new_mode = MODE_C;
          end
          (w_b == CH_ESC): begin
            w_emit  = 1'b1;
            w_edata = CH_ESC;
          end
          default: w_bad = 1'b1;
        endcase
      end
    end
  end

  // Scheduler state, error flag and output register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) begin
        r_mode[i] <= MODE_N;
      end
      r_esc <= '0;
      r_ptr <= '0;
      r_ov  <= 1'b0;
      r_od  <= 8'h00;
      r_oid <= '0;
      r_err <= 1'b0;
      r_eid <= '0;
    end else begin
      r_err <= w_bad;
      if (w_bad) r_eid <= w_gid;
      if (w_any) r_ptr <= w_ptr_nxt;
      if (w_set_esc) begin
        r_esc[w_gid] <= 1'b1;
      end else if (w_clr_esc) begin
        r_esc[w_gid] <= 1'b0;
      end
      if (w_set_mode) r_mode[w_gid] <= w_new_mode;
      if (w_emit) begin
        r_ov  <= 1'b1;
        r_od  <= w_edata;
        r_oid <= w_gid;
      end else if (out_ready) begin
        r_ov <= 1'b0;
      end
    end
  end

  // Pack per-requester modes onto the flat port
  always_comb begin
    w_mode = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_mode[2*i +: 2] = r_mode[i];
    end
  end

  assign mode      = w_mode;
  assign out_valid = r_ov;
  assign out_data  = r_od;
  assign out_id    = r_oid;
  assign cmd_err   = r_err;
  assign err_id    = r_eid;

endmodule
